// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl: collects operand A, operand B and opcode bytes from the
// UART receiver, drives registered ALU inputs, then returns the ALU result
// through the UART transmitter with a start/done handshake.
// Ports: i_clk, i_reset (async, active-high); i_rx_data/i_rx_done from RX;
// i_tx_done from TX; i_alu_result/i_alu_carry/i_alu_zero from the ALU;
// o_alu_a/o_alu_b/o_alu_op to the ALU; o_tx_data/o_tx_start to TX;
// o_busy (not idle), o_rx_drop (received byte discarded).
// Build option: define ALU_UART_FLAGS_EN to append a flag byte
// {zeros, carry, zero} after each result byte.
module alu_uart_ctrl #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_alu_carry,
  input  logic               i_alu_zero,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_rx_drop
);

  typedef enum logic [2:0] {
    WAIT_A   = 3'd0,
    WAIT_B   = 3'd1,
    WAIT_OP  = 3'd2,
    EXEC     = 3'd3,
    SEND_RES = 3'd4,
`ifdef ALU_UART_FLAGS_EN
    WAIT_RES = 3'd5,
    SEND_FLG = 3'd6,
    WAIT_FLG = 3'd7
`else
    WAIT_RES = 3'd5
`endif
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_rx_accept;

  logic [NB_DATA-1:0] r_alu_a;
  logic [NB_DATA-1:0] r_alu_b;
  logic [NB_OP-1:0]   r_alu_op;
  logic [NB_DATA-1:0] r_tx_data;
  logic               r_busy;
  logic               r_rx_drop;

`ifdef ALU_UART_FLAGS_EN
  logic [1:0] r_flags;
`else
  logic w_unused_flags;
  assign w_unused_flags = i_alu_carry ^ i_alu_zero;
`endif

  always_comb begin
    w_next      = r_state;
    w_rx_accept = 1'b0;
    unique case (r_state)
      WAIT_A: begin
        w_rx_accept = i_rx_done;
        if (i_rx_done) w_next = WAIT_B;
      end
      WAIT_B: begin
        w_rx_accept = i_rx_done;
        if (i_rx_done) w_next = WAIT_OP;
      end
      WAIT_OP: begin
        w_rx_accept = i_rx_done;
        if (i_rx_done) w_next = EXEC;
      end
      EXEC:     w_next = SEND_RES;
      SEND_RES: w_next = WAIT_RES;
      WAIT_RES: begin
`ifdef ALU_UART_FLAGS_EN
        if (i_tx_done) w_next = SEND_FLG;
`else
        if (i_tx_done) w_next = WAIT_A;
`endif
      end
`ifdef ALU_UART_FLAGS_EN
      SEND_FLG: w_next = WAIT_FLG;
      WAIT_FLG: if (i_tx_done) w_next = WAIT_A;
`endif
      default:  w_next = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= WAIT_A;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_tx_data <= '0;
      r_busy    <= 1'b0;
      r_rx_drop <= 1'b0;
`ifdef ALU_UART_FLAGS_EN
      r_flags   <= 2'b00;
`endif
    end else begin
      r_state   <= w_next;
      r_busy    <= (w_next != WAIT_A);
      r_rx_drop <= i_rx_done && !w_rx_accept;
      if (w_rx_accept && r_state == WAIT_A)
        r_alu_a <= i_rx_data;
      if (w_rx_accept && r_state == WAIT_B)
        r_alu_b <= i_rx_data;
      if (w_rx_accept && r_state == WAIT_OP)
        r_alu_op <= i_rx_data[NB_OP-1:0];
      if (r_state == EXEC) begin
        r_tx_data <= i_alu_result;
`ifdef ALU_UART_FLAGS_EN
        r_flags   <= {i_alu_carry, i_alu_zero};
`endif
      end
`ifdef ALU_UART_FLAGS_EN
      // Load the flag byte on entry so it is already stable while
      // the start pulse is high in SEND_FLG.
      if (r_state == WAIT_RES && i_tx_done)
        r_tx_data <= {{(NB_DATA-2){1'b0}}, r_flags};
`endif
    end
  end

  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_op   = r_alu_op;
  assign o_tx_data  = r_tx_data;
  assign o_busy     = r_busy;
  assign o_rx_drop  = r_rx_drop;
`ifdef ALU_UART_FLAGS_EN
  assign o_tx_start = (r_state == SEND_RES) || (r_state == SEND_FLG);
`else
  assign o_tx_start = (r_state == SEND_RES);
`endif

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// tb_alu_uart_ctrl: directed self-checking bench for alu_uart_ctrl with a
// small behavioural ALU closing the loop from operands to result/flags.
module tb_alu_uart_ctrl;
  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic [NB_DATA-1:0] rx_data;
  logic               rx_done;
  logic               tx_done;
  logic [NB_DATA-1:0] alu_result;
  logic               alu_carry;
  logic               alu_zero;
  logic [NB_DATA-1:0] alu_a;
  logic [NB_DATA-1:0] alu_b;
  logic [NB_OP-1:0]   alu_op;
  logic [NB_DATA-1:0] tx_data;
  logic               tx_start;
  logic               busy;
  logic               rx_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_uart_ctrl #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_tx_done    (tx_done),
    .i_alu_result (alu_result),
    .i_alu_carry  (alu_carry),
    .i_alu_zero   (alu_zero),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_op     (alu_op),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .o_busy       (busy),
    .o_rx_drop    (rx_drop)
  );

  // Behavioural ALU: carry output is signed overflow for add/sub.
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_op)
      6'h20: begin
        alu_result = alu_a + alu_b;
        alu_carry  = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      6'h22: begin
        alu_result = alu_a - alu_b;
        alu_carry  = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      6'h24: alu_result = alu_a & alu_b;
      6'h25: alu_result = alu_a | alu_b;
      6'h26: alu_result = alu_a ^ alu_b;
      6'h27: alu_result = ~(alu_a | alu_b);
      6'h00: alu_result = alu_a << alu_b;
      6'h02: alu_result = alu_a >> alu_b;
      6'h03: alu_result = $signed(alu_a) >>> alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic send_byte(input logic [7:0] d);
    rx_data = d;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = '0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  // One full transaction; optionally strobes a stray byte in WAIT_RES.
  task automatic txn(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] op, input logic [5:0] exp_op,
                     input logic [7:0] exp_res, input logic [7:0] exp_flg,
                     input bit drop, input string name);
    send_byte(a);
    checks++;
    if (alu_a !== a || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s opA: a=%h busy=%b want a=%h busy=1",
               name, alu_a, busy, a);
    end
    send_byte(b);
    checks++;
    if (alu_b !== b) begin
      errors++;
      $display("FAIL %s opB: got %h want %h", name, alu_b, b);
    end
    send_byte(op);
    checks++;
    if (alu_op !== exp_op || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL %s exec: op=%h start=%b want op=%h start=0",
               name, alu_op, tx_start, exp_op);
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== exp_res) begin
      errors++;
      $display("FAIL %s send_res: start=%b data=%h want start=1 data=%h",
               name, tx_start, tx_data, exp_res);
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0 || tx_data !== exp_res || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s wait_res: start=%b data=%h busy=%b want 0 %h 1",
               name, tx_start, tx_data, busy, exp_res);
    end
    if (drop) begin
      send_byte(8'hAA);
      checks++;
      if (rx_drop !== 1'b1 || busy !== 1'b1 || tx_start !== 1'b0) begin
        errors++;
        $display("FAIL %s drop: drop=%b busy=%b start=%b want 1 1 0",
                 name, rx_drop, busy, tx_start);
      end
      @(negedge clk);
      checks++;
      if (rx_drop !== 1'b0 || tx_data !== exp_res) begin
        errors++;
        $display("FAIL %s drop_end: drop=%b data=%h want 0 %h",
                 name, rx_drop, tx_data, exp_res);
      end
    end
    pulse_tx_done();
`ifdef ALU_UART_FLAGS_EN
    checks++;
    if (tx_start !== 1'b1 || tx_data !== exp_flg) begin
      errors++;
      $display("FAIL %s send_flg: start=%b data=%h want start=1 data=%h",
               name, tx_start, tx_data, exp_flg);
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s wait_flg: start=%b busy=%b want 0 1",
               name, tx_start, busy);
    end
    pulse_tx_done();
`else
    checks++;
    if (exp_flg > 8'h03) begin
      errors++;
      $display("FAIL %s flag_vec: got %h want <=03", name, exp_flg);
    end
`endif
    checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: busy=%b start=%b want 0 0",
               name, busy, tx_start);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy, rx_drop} !== '0) begin
      errors++;
      $display("FAIL reset: a=%h b=%h op=%h d=%h s=%b busy=%b drop=%b want 0",
               alu_a, alu_b, alu_op, tx_data, tx_start, busy, rx_drop);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    txn(8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 8'h00, 1'b0, "add");
  endtask

  task automatic test_sub_zero();
    txn(8'h03, 8'h03, 8'h22, 6'h22, 8'h00, 8'h01, 1'b0, "sub");
  endtask

  task automatic test_overflow();
    txn(8'h7F, 8'h01, 8'h20, 6'h20, 8'h80, 8'h02, 1'b0, "ovf");
  endtask

  task automatic test_back_to_back();
    txn(8'h0F, 8'hF0, 8'h26, 6'h26, 8'hFF, 8'h00, 1'b0, "b2b_xor");
    txn(8'h0F, 8'hF0, 8'h27, 6'h27, 8'h00, 8'h01, 1'b0, "b2b_nor");
  endtask

  task automatic test_drop();
    txn(8'h0F, 8'hF0, 8'h25, 6'h25, 8'hFF, 8'h00, 1'b1, "drop_or");
  endtask

  task automatic test_reset_mid();
    send_byte(8'h11);
    checks++;
    if (alu_a !== 8'h11 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: a=%h busy=%b want 11 1", alu_a, busy);
    end
    #2;
    rst = 1'b1;
    #2;
    checks++;
    if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy, rx_drop} !== '0) begin
      errors++;
      $display("FAIL rst_mid: a=%h b=%h op=%h d=%h s=%b busy=%b drop=%b want 0",
               alu_a, alu_b, alu_op, tx_data, tx_start, busy, rx_drop);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    txn(8'h02, 8'h01, 8'h02, 6'h02, 8'h01, 8'h00, 1'b0, "srl");
  endtask

  task automatic test_op_mask();
    txn(8'hF0, 8'h3C, 8'hE4, 6'h24, 8'h30, 8'h00, 1'b0, "and_mask");
  endtask

  initial begin
    rst     = 1'b1;
    rx_data = '0;
    rx_done = 1'b0;
    tx_done = 1'b0;
    test_reset();
    test_add();
    test_sub_zero();
    test_overflow();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    test_op_mask();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
